// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding, trap causes and XLEN for the PC sequencer
package pc_seq_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_TRAP   = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BOUNDS   = 2'b10;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC / next-state selection; bounds trap under PC_BOUNDS_CHECK_EN
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h200,
  parameter int              IMEM_BYTES  = 1024
) (
  input  state_e            state,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              resume,
  input  logic [XLEN-1:0]   incr_pc,
  input  logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   next_pc,
  output state_e            next_state,
  output logic              cnt_en,
  output logic [1:0]        trap_cause
);

  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);

  logic [XLEN-1:0] cand_pc;
  logic            advance;
  logic            bounds_hit;

`ifdef PC_BOUNDS_CHECK_EN
  assign bounds_hit = (cand_pc >= IMEM_LIMIT);
`else
  logic unused_bounds;
  assign unused_bounds = (cand_pc >= IMEM_LIMIT);
  assign bounds_hit    = 1'b0;
`endif

  // Pick the candidate advance address in RUN following the redirect priority
  always_comb begin
    cand_pc = incr_pc;
    advance = 1'b0;
    if (state == ST_RUN) begin
      if (branch_taken && (branch_target[1:0] == 2'b00)) begin
        cand_pc = branch_target;
        advance = 1'b1;
      end else if (!branch_taken && !halt_req && !stall) begin
        advance = 1'b1;
      end
    end
  end

  // Resolve next state, next pc, count enable and the cause of any trap entry
  always_comb begin
    next_pc    = pc;
    next_state = state;
    cnt_en     = 1'b0;
    trap_cause = CAUSE_NONE;
    case (state)
      ST_BOOT: begin
        next_state = ST_RUN;
      end
      ST_RUN: begin
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          next_pc    = TRAP_VECTOR;
          next_state = ST_TRAP;
          trap_cause = CAUSE_MISALIGN;
        end else if (advance) begin
          if (bounds_hit) begin
            next_pc    = TRAP_VECTOR;
            next_state = ST_TRAP;
            trap_cause = CAUSE_BOUNDS;
          end else begin
            next_pc = cand_pc;
            cnt_en  = 1'b1;
          end
        end else if (halt_req) begin
          next_state = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (resume) next_state = ST_RUN;
      end
      ST_TRAP: begin
        next_pc = TRAP_VECTOR;
        if (resume) next_state = ST_RUN;
      end
      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register stage feeding fetch; optional bounds trap via PC_BOUNDS_CHECK_EN
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = 64'h0,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h200,
  parameter int              IMEM_BYTES  = 1024,
  parameter int              CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   incr_pc,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  input  logic              halt_req,
  input  logic              resume,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_count
);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              trap_q, trap_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_en;
  logic [1:0]        sel_cause;

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR),
    .IMEM_BYTES  (IMEM_BYTES)
  ) u_next_sel (
    .state         (state_q),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .stall         (stall),
    .resume        (resume),
    .incr_pc       (incr_pc),
    .pc            (pc_q),
    .next_pc       (pc_d),
    .next_state    (state_d),
    .cnt_en        (cnt_en),
    .trap_cause    (sel_cause)
  );

  // Sticky trap flag/cause, saturating fetch counter and registered valid
  always_comb begin
    trap_d     = trap_q;
    cause_d    = cause_q;
    cnt_d      = cnt_q;
    pc_valid_d = (state_d == ST_RUN);
    if (state_q == ST_RUN && state_d == ST_TRAP) begin
      trap_d  = 1'b1;
      cause_d = sel_cause;
    end else if (state_q == ST_TRAP && state_d == ST_RUN) begin
      trap_d  = 1'b0;
      cause_d = CAUSE_NONE;
    end
    if (cnt_en && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Architectural registers; async reset returns to BOOT at RESET_PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      trap_q     <= 1'b0;
      cause_q    <= CAUSE_NONE;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      trap_q     <= trap_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign pc_valid    = pc_valid_q;
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign state       = state_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  localparam int          CNT_W = 4;
  localparam logic [63:0] TV    = 64'h200;
  localparam logic [63:0] IMEM  = 64'd1024;
`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [63:0]      incr_pc;
  logic             stall, branch_taken, halt_req, resume;
  logic [63:0]      branch_target;
  logic [63:0]      pc;
  logic             pc_valid, trap;
  logic [1:0]       trap_cause, state;
  logic [CNT_W-1:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model: state 0 boot, 1 run, 2 halted, 3 trap
  int          m_state;
  logic [63:0] m_pc;
  bit          m_trap;
  int          m_cause;
  int          m_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .incr_pc       (incr_pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .state         (state),
    .fetch_count   (fetch_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pc = 64'h0; m_trap = 0; m_cause = 0; m_cnt = 0;
  endtask

  task automatic enter_trap(input int cause);
    m_state = 3; m_pc = TV; m_trap = 1; m_cause = cause;
  endtask

  task automatic model_step();
    logic [63:0] cand;
    bit          adv;
    adv = 0;
    cand = 64'h0;
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (branch_taken && branch_target[1:0] != 2'b00) enter_trap(1);
      else if (branch_taken) begin cand = branch_target; adv = 1; end
      else if (halt_req) m_state = 2;
      else if (!stall) begin cand = incr_pc; adv = 1; end
      if (adv) begin
        if (BOUNDS && cand >= IMEM) enter_trap(2);
        else begin
          m_pc = cand;
          if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
        end
      end
    end else if (m_state == 2) begin
      if (resume) m_state = 1;
    end else begin
      if (resume) begin m_state = 1; m_trap = 0; m_cause = 0; end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    pc,                  m_pc);
    check({tag, ".state"}, 64'(state),          64'(m_state));
    check({tag, ".valid"}, 64'(pc_valid),       64'(m_state == 1));
    check({tag, ".trap"},  64'(trap),           64'(m_trap));
    check({tag, ".cause"}, 64'(trap_cause),     64'(m_cause));
    check({tag, ".cnt"},   64'(fetch_count),    64'(m_cnt));
  endtask

  // Called at a negedge: drive inputs, clock once, update model and compare
  task automatic cyc(input string tag, input bit br, input logic [63:0] tgt,
                     input bit st, input bit hr, input bit rs);
    branch_taken = br; branch_target = tgt; stall = st; halt_req = hr; resume = rs;
    incr_pc = m_pc + 64'd4;
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    incr_pc = 64'h4; stall = 0; branch_taken = 0; branch_target = 0; halt_req = 0; resume = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // boot then sequential fetch
    cyc("boot", 0, 0, 0, 0, 0);
    check("first_pc", pc, 64'h0);
    for (int i = 0; i < 4; i++) cyc("seq", 0, 0, 0, 0, 0);
    check("seq_pc_10", pc, 64'h10);
    // stall holds
    for (int i = 0; i < 3; i++) cyc("stall", 0, 0, 1, 0, 0);
    cyc("unstall", 0, 0, 0, 0, 0);
    check("unstall_pc", pc, 64'h14);
    // branch beats stall and halt
    cyc("br_prio", 1, 64'h40, 1, 1, 0);
    check("br_prio_pc", pc, 64'h40);
    // misaligned branch traps; resume restarts at trap vector
    cyc("misalign", 1, 64'h42, 0, 0, 0);
    check("misalign_cause", 64'(trap_cause), 64'd1);
    cyc("trap_hold", 1, 64'h80, 1, 1, 0);
    cyc("trap_resume", 0, 0, 0, 0, 1);
    check("resume_pc", pc, TV);
    // halt at 0x20, ignore branches while halted
    cyc("br20", 1, 64'h20, 0, 0, 0);
    cyc("halt", 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc("halted", i[0], 64'h100, 0, 0, 0);
    cyc("halt_resume", 0, 0, 0, 0, 1);
    check("halt_resume_pc", pc, 64'h20);
    cyc("after_halt", 0, 0, 0, 0, 0);
    check("after_halt_pc", pc, 64'h24);
    // edge of instruction memory
    cyc("br3fc", 1, 64'h3FC, 0, 0, 0);
    cyc("edge", 0, 0, 0, 0, 0);
    check("edge_pc", pc, BOUNDS ? TV : 64'h400);
    cyc("edge_resume", 0, 0, 0, 0, 1);

    // randomized traffic with occasional async reset
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] tgt;
      bit          br, st, hr, rs;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      br = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 4) == 0);
      hr = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 3) == 0);
      tgt = 64'($urandom_range(0, 320)) << 2;
      if ($urandom_range(0, 7) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) tgt = {$urandom, $urandom} & ~64'h3;
      branch_taken = br; branch_target = tgt; stall = st; halt_req = hr; resume = rs;
      incr_pc = ($urandom_range(0, 9) == 0) ? (64'($urandom_range(0, 300)) << 2) : m_pc + 64'd4;
      @(posedge clk);
      #1;
      model_step();
      check_all("rand");
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage sitting directly upstream of the instruction fetch block.
- Holds the architectural 64-bit PC and drives it into fetch. Selects the next PC from the fetch-supplied incremented PC (PC+4), a taken-branch target, or the trap vector.
- Sequences boot, run, halt and trap states, and keeps a fetch counter for debug and performance.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- TRAP_VECTOR, 64'h200, PC loaded on entry to TRAP.
- IMEM_BYTES, 1024, instruction memory size in bytes; used only by the optional bounds check.
- CNT_W, 32, width of fetch_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- incr_pc  in  64  PC+4 returned by fetch.
- stall  in  1  hold PC; re-present the same instruction.
- branch_taken  in  1  redirect request.
- branch_target  in  64  redirect address.
- halt_req  in  1  stop fetching.
- resume  in  1  leave HALTED or TRAP.
- pc  out  64  current fetch address.
- pc_valid  out  1  pc holds a real fetch this cycle.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  00 none, 01 misaligned branch, 10 out of bounds.
- state  out  2  00 BOOT, 01 RUN, 10 HALTED, 11 TRAP.
- fetch_count  out  CNT_W  number of PC advances in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, pc_valid=0, trap=0, trap_cause=00, fetch_count=0.
  - Reset asserted mid-operation overrides everything immediately.
- All state and pc are registered on the rising clk edge; outputs are direct register values, so there are no combinational input-to-output paths.
- pc_valid=1 exactly when state==RUN.
- BOOT:
  - Unconditionally moves to RUN on the first edge after reset release.
  - pc unchanged, so the first fetch is RESET_PC.
  - All inputs are ignored.
- RUN, next-PC priority (highest first):
  1. branch_taken with branch_target[1:0]!=0: pc=TRAP_VECTOR, state=TRAP, trap=1, trap_cause=01.
  2. branch_taken, aligned: pc=branch_target. Overrides stall and halt_req in the same cycle.
  3. halt_req: pc held, state=HALTED.
  4. stall: pc held, state stays RUN.
  5. Otherwise: pc=incr_pc.
- fetch_count:
  - Increments only on cases 2 and 5.
  - Saturates at all-ones; no wrap.
  - Not incremented on stall, halt or trap entry.
- HALTED:
  - pc held; branch_taken, stall and halt_req are ignored.
  - resume=1 returns to RUN with pc unchanged, so the fetch that was pending at halt restarts.
- TRAP:
  - pc=TRAP_VECTOR; trap and trap_cause held.
  - resume=1 returns to RUN, clears trap to 0 and trap_cause to 00; first fetch is TRAP_VECTOR.
  - All other inputs are ignored.
- Arithmetic: incr_pc is taken as supplied; it wraps naturally at 2^64 and no carry is checked.
- branch_target is used unmodified when aligned.
- resume asserted while in RUN or BOOT is ignored.

Optional Feature:
- Macro PC_BOUNDS_CHECK_EN.
- When defined:
  - In RUN, a candidate next PC from case 2 or 5 that is >= IMEM_BYTES takes the trap path instead: pc=TRAP_VECTOR, state=TRAP, trap=1, trap_cause=10, fetch_count not incremented.
  - A misaligned target (cause 01) has priority over out of bounds.
- When undefined:
  - No range check; code 10 is never produced.
  - Out-of-range addresses wrap inside fetch's memory indexing.

Decomposition:
- Shared package pc_seq_pkg holds:
  - the 2-bit state enum (BOOT, RUN, HALTED, TRAP);
  - trap cause constants (CAUSE_NONE, CAUSE_MISALIGN, CAUSE_BOUNDS);
  - the XLEN=64 constant, also used by the fetch stage.
- One combinational sub-module, pc_next_sel:
  - inputs: state, the control inputs, incr_pc, branch_target and pc;
  - outputs: next_pc, next_state, a count-enable and the trap cause.
- pc_sequencer itself holds only the registers.

Test Plan:
1. Reset release with RESET_PC=0, all inputs 0 and incr_pc driven as pc+4 → cycle 1 BOOT (pc_valid=0); cycle 2 pc=0 with pc_valid=1; then pc=4, 8, 12; fetch_count=3 after three advances.
2. pc=0x10 with stall=1 for 3 cycles, then stall=0 → pc holds 0x10 for 3 cycles, then 0x14; fetch_count unchanged during the stall.
3. branch_taken=1, branch_target=0x40, and stall=1 plus halt_req=1 in the same cycle → next pc=0x40, state=RUN, fetch_count+1.
4. branch_target=0x42 → pc=0x200, state=TRAP, trap=1, trap_cause=01, pc_valid=0; resume=1 → RUN with pc=0x200 and trap=0.
5. halt_req at pc=0x20 → HALTED with pc=0x20 held for 5 cycles while branch_taken toggles; resume → pc=0x20 valid, next pc=0x24.
6. With PC_BOUNDS_CHECK_EN and pc=0x3FC, incr_pc=0x400 → TRAP, trap_cause=10; without the macro, next pc=0x400.
